// File: rtl/note_decoder_pkg.sv
// +--------------------------------------------------------------------------+
// | note_decoder_pkg : shared note table and decoder codes/types             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package note_decoder_pkg;

    localparam int         c_num_notes   = 14;
    localparam logic [5:0] c_code_silent  = 6'd0;
    localparam logic [5:0] c_code_unknown = 6'd63;
    localparam int         c_tol_shift    = 6;

    // Tone player's half-period table (low do..si, then mid do..si), in clocks.
    localparam logic [31:0] c_player_half_period [c_num_notes] = '{
        32'd190840, 32'd170068, 32'd151515, 32'd143266,
        32'd127551, 32'd113636, 32'd101215,
        32'd95602,  32'd85179,  32'd75873,  32'd71633,
        32'd63776,  32'd56818,  32'd50607
    };

    typedef enum logic [1:0] {
        ST_SILENT  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/note_decoder_if.sv
// +--------------------------------------------------------------------------+
// | note_decoder_if : tone input and decoded-note outputs of note_decoder    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface note_decoder_if;
    logic        pwm_in;
    logic [5:0]  note_code;
    logic        note_valid;
    logic [31:0] prev_len;
    logic        locked;

    modport master (
        output pwm_in,
        input  note_code, note_valid, prev_len, locked
    );

    modport slave (
        input  pwm_in,
        output note_code, note_valid, prev_len, locked
    );
endinterface

`default_nettype wire

// File: rtl/note_decoder_period_matcher.sv
// +--------------------------------------------------------------------------+
// | period_matcher : maps a measured half-period to a note code (63 = none)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module period_matcher
    import note_decoder_pkg::*;
#(
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic [31:0] meas_i,
    output logic [5:0]  code_o
);

    logic [c_num_notes-1:0] w_hit;

    for (genvar k = 0; k < c_num_notes; k++) begin : g_note
        localparam logic [31:0] c_h   = (c_player_half_period[k] >> PERIOD_SHIFT) + 32'd1;
        localparam logic [31:0] c_tol = c_h >> c_tol_shift;
        logic [31:0] w_diff;
        assign w_diff   = (meas_i >= c_h) ? (meas_i - c_h) : (c_h - meas_i);
        assign w_hit[k] = (w_diff <= c_tol);
    end

    // Windows do not overlap; lowest index wins only as a tie-break.
    always_comb begin
        code_o = c_code_unknown;
        for (int k = c_num_notes - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                code_o = 6'(k + 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_decoder.sv
// +--------------------------------------------------------------------------+
// | note_decoder : recognises tone-player notes from a square-wave input     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module note_decoder
    import note_decoder_pkg::*;
#(
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned SILENCE_TIMEOUT = 400000,
    parameter int unsigned PERIOD_SHIFT    = 0
) (
    input  logic           clk,
    input  logic           rst,
    note_decoder_if.slave  bus_if
);

    localparam logic [3:0] c_lock = 4'(LOCK_COUNT);

    logic        sync1_q, sync2_q, level_q;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] prev_len_q, prev_len_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [5:0]  cand_code_q, cand_code_d;
    logic [5:0]  note_code_q, note_code_d;
    logic        note_valid_q, note_valid_d;
    state_e      state_q, state_d;

    logic        w_edge;
    logic        w_timeout;
    logic        w_change;
    logic [5:0]  w_cand;

    assign w_edge    = sync2_q ^ level_q;
    assign w_timeout = (half_cnt_q == SILENCE_TIMEOUT);

    period_matcher #(
        .PERIOD_SHIFT (PERIOD_SHIFT)
    ) u_matcher (
        .meas_i (half_cnt_q),
        .code_o (w_cand)
    );

    always_comb begin
        state_d     = state_q;
        cand_code_d = cand_code_q;
        match_cnt_d = match_cnt_q;
        note_code_d = note_code_q;

        case (state_q)
            ST_SILENT: begin
                // The first edge only opens a measurement window.
                if (w_edge) begin
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = 4'd0;
                end
            end
            ST_ACQUIRE: begin
                if (w_edge) begin
                    if (w_cand == cand_code_q) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                    end else begin
                        cand_code_d = w_cand;
                        match_cnt_d = 4'd1;
                    end
                    if (match_cnt_d == c_lock) begin
                        state_d     = ST_LOCKED;
                        note_code_d = cand_code_d;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_edge && (w_cand != note_code_q)) begin
                    state_d     = ST_ACQUIRE;
                    cand_code_d = w_cand;
                    match_cnt_d = 4'd1;
                end
            end
            default: state_d = ST_SILENT;
        endcase

        if (!w_edge && w_timeout) begin
            state_d     = ST_SILENT;
            note_code_d = c_code_silent;
        end
    end

    assign w_change     = (note_code_d != note_code_q);
    assign note_valid_d = w_change;
    assign prev_len_d   = w_change ? hold_cnt_q : prev_len_q;
    assign hold_cnt_d   = w_change ? 32'd1 :
                          ((hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 32'd1);
    assign half_cnt_d   = w_edge ? 32'd1 :
                          ((half_cnt_q == '1) ? half_cnt_q : half_cnt_q + 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            half_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            prev_len_q   <= '0;
            match_cnt_q  <= '0;
            cand_code_q  <= c_code_silent;
            note_code_q  <= c_code_silent;
            note_valid_q <= 1'b0;
            state_q      <= ST_SILENT;
        end else begin
            sync1_q      <= bus_if.pwm_in;
            sync2_q      <= sync1_q;
            level_q      <= sync2_q;
            half_cnt_q   <= half_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_len_q   <= prev_len_d;
            match_cnt_q  <= match_cnt_d;
            cand_code_q  <= cand_code_d;
            note_code_q  <= note_code_d;
            note_valid_q <= note_valid_d;
            state_q      <= state_d;
        end
    end

    assign bus_if.note_code  = note_code_q;
    assign bus_if.note_valid = note_valid_q;
    assign bus_if.prev_len   = prev_len_q;
    assign bus_if.locked     = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_note_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_note_decoder : directed + random tone sequences against a note model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_note_decoder;

    // Period table scaled by 2^8 and a short timeout keep the run short.
    localparam int LOCK_COUNT      = 4;
    localparam int SILENCE_TIMEOUT = 1000;
    localparam int PERIOD_SHIFT    = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   obs_pulses = 0;
    int   exp_pulses = 0;

    note_decoder_if bus_if();

    note_decoder #(
        .LOCK_COUNT      (LOCK_COUNT),
        .SILENCE_TIMEOUT (SILENCE_TIMEOUT),
        .PERIOD_SHIFT    (PERIOD_SHIFT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned tbl [14] = '{190840, 170068, 151515, 143266, 127551, 113636, 101215,
                              95602, 85179, 75873, 71633, 63776, 56818, 50607};

    typedef struct {
        int cyc;
        int code;
        int plen;
    } pulse_t;

    pulse_t exp_q [$];

    // Behavioural note model: tone runs, current note, last change time.
    bit m_active;
    int m_run_code, m_run_len, m_note, m_prev_gap, m_last_pulse;

    function automatic int half_of(input int code);
        return int'(tbl[code-1] >> PERIOD_SHIFT) + 1;
    endfunction

    function automatic int ref_code(input int m);
        int h, d;
        for (int k = 1; k <= 14; k++) begin
            h = half_of(k);
            d = (m > h) ? m - h : h - m;
            if (d <= h / 64) return k;
        end
        return 63;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int at, input int code);
        pulse_t e;
        e.cyc  = at;
        e.code = code;
        e.plen = (m_last_pulse >= 0) ? at - m_last_pulse : -1;
        m_last_pulse = at;
        m_note = code;
        exp_pulses++;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_run_code = 0;
        m_run_len = 0;
        m_note = 0;
        m_prev_gap = 0;
        m_last_pulse = -1;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_code"}, 32'(bus_if.note_code), 32'(m_note));
        check({tag, "_locked"}, 32'(bus_if.locked), (m_active && m_run_len >= LOCK_COUNT) ? 32'd1 : 32'd0);
    endtask

    // Toggle the line, then hold it for g clocks. DUT outputs react 3 clocks after a toggle.
    task automatic half(input int g, input string tag);
        int t0, c;
        t0 = cyc;
        bus_if.pwm_in = ~bus_if.pwm_in;
        if (!m_active) begin
            m_active = 1'b1;
            m_run_len = 0;
            m_run_code = 0;
        end else begin
            c = ref_code(m_prev_gap);
            if (c == m_run_code) m_run_len++;
            else begin
                m_run_code = c;
                m_run_len = 1;
            end
            if (m_run_len == LOCK_COUNT && c != m_note) push(t0 + 3, c);
        end
        if (g > SILENCE_TIMEOUT) begin
            if (m_note != 0) push(t0 + 3 + SILENCE_TIMEOUT, 0);
            m_active = 1'b0;
            m_run_len = 0;
        end
        m_prev_gap = g;
        repeat (g) @(posedge clk);
        #1;
        if (g >= 4 && !(g > SILENCE_TIMEOUT && g < SILENCE_TIMEOUT + 4)) check_state(tag);
    endtask

    always @(negedge clk) begin : mon
        pulse_t e;
        if (!rst && bus_if.note_valid) begin
            obs_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus_if.note_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("valid_code", 32'(bus_if.note_code), 32'(e.code));
                if (e.plen >= 0) check("prev_len", bus_if.prev_len, 32'(e.plen));
            end
        end
    end

    int sel, n, g, code, j;

    initial begin
        rst = 1'b1;
        bus_if.pwm_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", 32'(bus_if.note_code), 32'd0);
        check("rst_valid", 32'(bus_if.note_valid), 32'd0);
        check("rst_prev_len", bus_if.prev_len, 32'd0);
        check("rst_locked", 32'(bus_if.locked), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        repeat (6) half(half_of(8), "mid_do");
        repeat (6) half(half_of(12), "mid_sol");
        repeat (6) half(379, "mid_do_tol");
        repeat (6) half(312, "unknown");
        half(SILENCE_TIMEOUT, "edge_vs_timeout");
        half(SILENCE_TIMEOUT + 20, "silence");

        repeat (10) begin
            half(half_of(8), "alt_a");
            half(half_of(12), "alt_b");
        end
        half(SILENCE_TIMEOUT + 20, "alt_silence");

        repeat (6) half(half_of(5), "low_sol");
        check("pulses_before_reset", 32'(obs_pulses), 32'(exp_pulses));
        rst = 1'b1;
        bus_if.pwm_in = 1'b0;
        #1;
        check("midlock_rst_code", 32'(bus_if.note_code), 32'd0);
        check("midlock_rst_valid", 32'(bus_if.note_valid), 32'd0);
        check("midlock_rst_prev_len", bus_if.prev_len, 32'd0);
        check("midlock_rst_locked", 32'(bus_if.locked), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        repeat (6) half(half_of(5), "relock");

        repeat (8) begin
            sel = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 5));
            if (sel <= 1) begin
                code = int'($urandom_range(1, 14));
                j = half_of(code) >> 7;
                g = half_of(code) - j + int'($urandom_range(0, 2 * j));
            end else if (sel == 2) begin
                g = int'($urandom_range(150, 900));
            end else begin
                g = int'($urandom_range(SILENCE_TIMEOUT - 2, SILENCE_TIMEOUT + 30));
            end
            repeat (n) half(g, "random");
        end

        half(SILENCE_TIMEOUT + 20, "final_silence");
        repeat (SILENCE_TIMEOUT) @(posedge clk);
        #1;
        check("pulse_count", 32'(obs_pulses), 32'(exp_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive matching half-periods needed to accept a note (range 2..15).
REQ-002 SHALL have parameter SILENCE_TIMEOUT, default 400000, meaning the number of clocks without an edge before silence is declared.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pwm_in, input, 1 bit: asynchronous tone square wave, as driven by the team's tone/melody player pwm output.
REQ-006 SHALL have port note_code, output, 6 bits: currently recognised note; 0 = silence, 1..7 = low do..si, 8..14 = mid do..si, 63 = unrecognised.
REQ-007 SHALL have port note_valid, output, 1 bit: one-clock pulse each time note_code changes.
REQ-008 SHALL have port prev_len, output, 32 bits: clocks the previous note_code was held; valid while note_valid is high.
REQ-009 SHALL have port locked, output, 1 bit: high while the state is LOCKED.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchroniser; an edge cycle is any cycle where the synchronised value differs from its previous registered value.
REQ-011 SHALL keep half_cnt, a 32-bit count that saturates at all-ones, of clocks since the last edge cycle; on an edge cycle the measured half-period M = half_cnt, and half_cnt reloads to 1.
REQ-012 SHALL map M to a candidate code: code k matches when |M - H_k| <= H_k>>6, where H_k = table constant + 1; no match gives 63.
REQ-013 SHALL use table constants, in clocks: low 190840,170068,151515,143266,127551,113636,101215; mid 95602,85179,75873,71633,63776,56818,50607.
REQ-014 SHALL implement states SILENT (reset state), ACQUIRE and LOCKED.
REQ-015 SILENT: the first edge cycle SHALL move to ACQUIRE with match_cnt=0; that first edge SHALL yield no measurement.
REQ-016 ACQUIRE: each edge cycle SHALL compare the candidate with the stored cand_code; if equal, match_cnt increments, otherwise cand_code takes the new candidate and match_cnt=1.
REQ-017 When match_cnt reaches LOCK_COUNT, the FSM SHALL enter LOCKED; if cand_code differs from note_code, it SHALL update note_code with a note_valid pulse on the next cycle.
REQ-018 LOCKED: an edge whose candidate equals note_code SHALL keep the lock; a differing candidate SHALL return to ACQUIRE with cand_code=candidate and match_cnt=1, leaving note_code unchanged.
REQ-019 In any state, when half_cnt reaches SILENCE_TIMEOUT, the FSM SHALL go to SILENT; if note_code is not 0, it SHALL set note_code=0 with a note_valid pulse.
REQ-020 An edge and the timeout in the same cycle: the edge SHALL win.
REQ-021 hold_cnt SHALL count clocks since the last note_code change, saturating at all-ones; on a change, prev_len=hold_cnt and hold_cnt reloads to 1.
REQ-022 Latency from the edge that completes the lock to the note_valid pulse SHALL be exactly 1 clock, and at most 2 clocks from the timeout cycle.
REQ-023 note_valid SHALL never assert on consecutive cycles, and SHALL never assert without a change in note_code.

Reset
REQ-024 Asserting rst SHALL immediately give: note_code=0, note_valid=0, prev_len=0, locked=0, state SILENT, half_cnt=hold_cnt=match_cnt=0, cand_code=0, and synchroniser flops 0.
REQ-025 After reset, the first synchronised high level SHALL count as an edge and SHALL move the FSM to ACQUIRE.
REQ-026 Reset mid-lock SHALL discard all history and SHALL NOT emit a note_valid pulse.

Structure
REQ-027 The 14 half-period constants, the code values (SILENT=0, UNKNOWN=63) and the tolerance shift (6) SHALL live in a shared package, alongside the player's note table.
REQ-028 A combinational sub-module period_matcher SHALL map M to the candidate code; the FSM and counters SHALL stay in note_decoder.

Verification
REQ-029 Square wave with half-period 95603 clocks -> note_code 8 and one note_valid 1 clock after the 5th edge (4th measurement); locked=1.
REQ-030 Then switch to 63777-clock half-periods -> note_code 12 after 4 new half-periods; prev_len equals the clocks since code 8 was set.
REQ-031 Half-period 97000 clocks (within tolerance of 95603) -> code 8. Half-period 80000 clocks -> code 63 after 4 half-periods.
REQ-032 Hold the line static after a lock -> note_code 0 and note_valid once, at SILENCE_TIMEOUT clocks after the last edge; no further pulses.
REQ-033 Alternate half-periods of 95603 and 63777 -> never locks; note_code and note_valid unchanged.
REQ-034 rst pulse while locked on code 5 -> outputs 0 immediately, no pulse; relock on code 5 after LOCK_COUNT+1 edges.
